scan_fifo: RTL and testbench
============================

# scan_fifo

Parametrised synchronous FIFO with a built-in mux-D scan chain. It is the next generation of the team's fixed 17-bit, 8-entry scan FIFO and adds configurable width and depth, occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags. It sits between producer and consumer logic in the same clock domain. The control and output registers are stitched into one serial chain for DFT load, capture and unload.

## Interface
- `DATA_W`, 17: data width in bits.
- `DEPTH`, 8: number of entries; must be a power of two and ≥ 2. `AW` = log2(DEPTH).
- `AF_LVL`, DEPTH-1: `almost_full` asserts when count ≥ AF_LVL.
- `AE_LVL`, 1: `almost_empty` asserts when count ≤ AE_LVL.

- `clk` in 1: single clock; all flops are rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `w_en` in 1: write request.
- `r_en` in 1: read request.
- `data_in` in DATA_W: write data.
- `data_out` out DATA_W: registered read data.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out AW+1: occupancy.
- `almost_full` out 1: see `AF_LVL`.
- `almost_empty` out 1: see `AE_LVL`.
- `overflow` out 1: sticky; set by a write attempted while full.
- `underflow` out 1: sticky; set by a read attempted while empty.
- `SI` in 1: scan in.
- `TM` in 1: test mode / scan enable.
- `SO` out 1: scan out.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are AW+1 bits wide. The extra bit is the wrap bit.
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
  - `full`: low AW bits are equal and the wrap bits differ.
  - `empty`: the pointers are equal.
  - Pointer increments wrap naturally.
- Accepted write (`w_en` && !`full` && !`TM`):
  - mem[wr_ptr[AW-1:0]] <= `data_in`.
  - `wr_ptr` increments.
- Accepted read (`r_en` && !`empty` && !`TM`):
  - `data_out` <= mem[rd_ptr[AW-1:0]].
  - `rd_ptr` increments.
  - `data_out` holds its value whenever no read is accepted.
- Simultaneous read and write, with both accepted: count is unchanged.
- Write while full: dropped and `overflow` is set. A simultaneous read still proceeds, so no same-cycle write-through occurs when full.
- Read while empty: ignored and `underflow` is set. A simultaneous write still proceeds, so there is no bypass.
- `overflow` and `underflow` are cleared only by `rst` or by scan load.
- Scan chain vector, MSB first: S = {data_out, wr_ptr, rd_ptr, overflow, underflow}. Length L = DATA_W + 2·(AW+1) + 2, which is 27 at the default parameters.
- While `TM`=1, each cycle:
  - S <= {S[L-2:0], SI}.
  - SO = S[L-1], taken combinationally from a flop output.
  - The memory array holds its contents and functional updates are blocked.
- While `TM`=0:
  - The chain registers update functionally; that update is the capture.
  - SO still shows S[L-1].

## Timing
- Reset values: `data_out`=0, both pointers 0, `overflow`=`underflow`=0. Resulting outputs are `empty`=1, `full`=0, `count`=0, `almost_empty`=1, `almost_full`=0 (when AF_LVL>0), `SO`=0.
- Memory is not reset.
- `rst` asserted mid-operation clears the pointers and flags immediately, whatever `TM` is. Deassertion is synchronous to `clk` via the integrating top.
- Read latency is one cycle: `data_out` is valid the cycle after the accepting edge.
- Flags and count are combinational from the pointers, so they update the cycle after the accepting edge.
- Scan load takes L `TM` cycles, capture takes one `TM`=0 cycle, and unload takes L `TM` cycles (SO shows `data_out`[DATA_W-1] first).

## Structure
- Package `scan_fifo_pkg`:
  - `clog2` function.
  - chain-length function L(DATA_W, AW).
  - Chain field offset constants.
- Sub-module `scan_fifo_mem`: DEPTH×DATA_W register array with a write port and an asynchronous read port. It has no reset and no scan.
- Top level holds the pointers, flags, output register and scan mux.

## Test plan
All scenarios use the default parameters (L=27).
1. Reset, then write 0..7 → `full`=1, `count`=8, `almost_full`=1; the 9th write sets `overflow`=1 and count stays 8.
2. Read 8 entries → `data_out` = 0..7, each one cycle after its accepting edge; `empty`=1; the 9th read sets `underflow`=1 and `data_out` stays 7.
3. Fill to 4, then 20 cycles with `w_en`=`r_en`=1 and data 100.. → `count` stays 4, pointers wrap, and read data is in order with no loss.
4. Write 0..6, then `TM`=1 and shift in 27 bits with `wr_ptr`=5, `rd_ptr`=2, flags 0 → shows `count`=3. Then one `TM`=0 cycle with `r_en`=1 → `data_out`=2. Then `TM`=1 for 27 cycles → the first 17 SO bits are 2 (MSB first), the next 8 bits are `wr_ptr`=0101 then `rd_ptr`=0011, and the last two bits are 00.
5. `TM`=1 with `w_en`=`r_en`=1 for 10 cycles → the memory is unchanged; the earlier contents read back correctly after a pointer reload.
6. Assert `rst` mid-burst and mid-scan → all outputs go to their reset values asynchronously; with `TM`=0 the next accepted write/read sequence is correct.

Source files
------------

// File: rtl/scan_fifo_pkg.sv
`default_nettype none
// scan_fifo_pkg: sizing helpers and scan-chain field offsets shared by scan_fifo.
package scan_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Chain is {data_out, wr_ptr, rd_ptr, overflow, underflow}, MSB first.
  function automatic int chain_len(input int dw, input int aw);
    return dw + 2 * (aw + 1) + 2;
  endfunction

  localparam int OFF_UNF = 0;
  localparam int OFF_OVF = 1;
  localparam int OFF_RD  = 2;

  function automatic int off_wr(input int aw);
    return OFF_RD + aw + 1;
  endfunction

  function automatic int off_dout(input int aw);
    return OFF_RD + 2 * (aw + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_fifo_mem.sv
`default_nettype none
// scan_fifo_mem: DEPTH x DATA_W storage, one write port, asynchronous read port.
module scan_fifo_mem #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/scan_fifo.sv
`default_nettype none
// scan_fifo: parametrised synchronous FIFO whose pointers, flags and output
// register form one mux-D scan chain.
module scan_fifo
  import scan_fifo_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic                   r_en,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   SI,
  input  logic                   TM,
  output logic                   SO
);

  localparam int AW       = clog2(DEPTH);
  localparam int L        = chain_len(DATA_W, AW);
  localparam int OFF_WR   = off_wr(AW);
  localparam int OFF_DOUT = off_dout(AW);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] AF_TH   = (AW + 1)'(AF_LVL);
  localparam logic [AW:0] AE_TH   = (AW + 1)'(AE_LVL);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [DATA_W-1:0] rd_data;
  logic              wr_acc, rd_acc;
  logic [L-1:0]      chain, shifted;

  assign full   = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty  = (wr_q == rd_q);
  assign count  = wr_q - rd_q;
  assign wr_acc = w_en && !full && !TM;
  assign rd_acc = r_en && !empty && !TM;

  scan_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign chain   = {dout_q, wr_q, rd_q, ovf_q, unf_q};
  assign shifted = {chain[L-2:0], SI};

  always_comb begin
    dout_d = dout_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (TM) begin
      dout_d = shifted[OFF_DOUT +: DATA_W];
      wr_d   = shifted[OFF_WR +: AW + 1];
      rd_d   = shifted[OFF_RD +: AW + 1];
      ovf_d  = shifted[OFF_OVF];
      unf_d  = shifted[OFF_UNF];
    end else begin
      if (wr_acc) wr_d = wr_q + PTR_ONE;
      if (rd_acc) begin
        rd_d   = rd_q + PTR_ONE;
        dout_d = rd_data;
      end
      // Rejected requests are recorded but never disturb the other port.
      if (w_en && full)  ovf_d = 1'b1;
      if (r_en && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign data_out     = dout_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);
  assign SO           = chain[L-1];

endmodule
`default_nettype wire

// File: tb/tb_scan_fifo.sv
`default_nettype none
// tb_scan_fifo: directed scoreboard bench for scan_fifo at default parameters.
module tb_scan_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_en = 1'b0, r_en = 1'b0, SI = 1'b0, TM = 1'b0;
  logic [16:0] data_in = '0;
  logic [16:0] data_out;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow, SO;

  scan_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .r_en         (r_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .SI           (SI),
    .TM           (TM),
    .SO           (SO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  logic [16:0] mmem [8];
  logic [3:0]  mwr, mrd;
  logic [16:0] mdout;
  logic        movf, munf;
  logic [26:0] got;

  function automatic int mcnt();
    logic [3:0] d;
    d = mwr - mrd;
    return int'(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mwr = '0; mrd = '0; mdout = '0; movf = 1'b0; munf = 1'b0;
    sb.delete();
  endtask

  task automatic rebuild();
    sb.delete();
    for (int k = 0; k < mcnt(); k++) sb.push_back(mmem[3'(mrd + 4'(k))]);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_dout"},  data_out, mdout);
    chk({tag, "_count"}, count, mcnt());
    chk({tag, "_full"},  full, mcnt() == 8);
    chk({tag, "_empty"}, empty, mcnt() == 0);
    chk({tag, "_af"},    almost_full, mcnt() >= 7);
    chk({tag, "_ae"},    almost_empty, mcnt() <= 1);
    chk({tag, "_ovf"},   overflow, movf);
    chk({tag, "_unf"},   underflow, munf);
    chk({tag, "_so"},    SO, mdout[16]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dout"},  data_out, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"},  full, 0);
    chk({tag, "_ae"},    almost_empty, 1);
    chk({tag, "_af"},    almost_full, 0);
    chk({tag, "_ovf"},   overflow, 0);
    chk({tag, "_unf"},   underflow, 0);
    chk({tag, "_so"},    SO, 0);
  endtask

  // One functional cycle; the model decides acceptance from its own occupancy.
  task automatic cycle(input string tag, input logic we, input logic re, input logic [16:0] din);
    bit wa, ra;
    TM = 1'b0; w_en = we; r_en = re; data_in = din;
    wa = we && (mcnt() != 8);
    ra = re && (mcnt() != 0);
    if (wa) begin
      sb.push_back(din);
      mmem[mwr[2:0]] = din;
    end
    if (we && !wa) movf = 1'b1;
    if (re && !ra) munf = 1'b1;
    step();
    w_en = 1'b0; r_en = 1'b0;
    if (ra) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $error("FAIL %s_sb observed=empty_queue expected=entry", tag);
      end else begin
        mdout = sb.pop_front();
      end
    end
    if (wa) mwr = mwr + 4'd1;
    if (ra) mrd = mrd + 4'd1;
    check_state(tag);
  endtask

  task automatic scan_load(input string tag, input logic [26:0] v, input logic we, input logic re);
    TM = 1'b1; w_en = we; r_en = re; data_in = 17'h1ABCD;
    for (int i = 26; i >= 0; i--) begin
      SI = v[i];
      step();
    end
    TM = 1'b0; w_en = 1'b0; r_en = 1'b0; SI = 1'b0;
    mdout = v[26:10]; mwr = v[9:6]; mrd = v[5:2]; movf = v[1]; munf = v[0];
    rebuild();
    check_state(tag);
  endtask

  task automatic scan_unload(output logic [26:0] g);
    TM = 1'b1; SI = 1'b0; w_en = 1'b0; r_en = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      g[i] = SO;
      step();
    end
    TM = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario 1: reset, fill, overflow.
    #12;
    chk_reset("rst_init");
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 17'(i));
    cycle("ovf_write", 1'b1, 1'b0, 17'h1FFFF);

    // Scenario 2: drain, underflow, data_out holds.
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 1'b1, '0);
    cycle("unf_read", 1'b0, 1'b1, '0);

    // Scenario 3: steady-state simultaneous traffic across pointer wrap.
    for (int i = 0; i < 4; i++) cycle("prefill", 1'b1, 1'b0, 17'(10 + i));
    for (int i = 0; i < 20; i++) cycle("rw", 1'b1, 1'b1, 17'(100 + i));

    // Scenario 4: scan load, capture, unload.
    rst = 1'b1; #1;
    chk_reset("rst_s4");
    step(); rst = 1'b0; model_reset();
    for (int i = 0; i < 7; i++) cycle("w07", 1'b1, 1'b0, 17'(i));
    scan_load("load1", {17'd0, 4'd5, 4'd2, 2'b00}, 1'b0, 1'b0);
    chk("load1_cnt3", count, 3);
    cycle("capture", 1'b0, 1'b1, '0);
    chk("capture_dout2", data_out, 2);
    scan_unload(got);
    chk("unload_dout", got[26:10], 2);
    chk("unload_wr", got[9:6], 4'b0101);
    chk("unload_rd", got[5:2], 4'b0011);
    chk("unload_flags", got[1:0], 2'b00);
    check_state("after_unload");

    // Scenario 5: TM blocks memory writes and reads.
    TM = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 17'h1ABCD; SI = 1'b0;
    for (int i = 0; i < 10; i++) step();
    scan_load("load2", {17'd0, 4'd7, 4'd0, 2'b00}, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle("reread", 1'b0, 1'b1, '0);
    chk("reread_last", data_out, 6);

    // Scenario 6: asynchronous reset mid-burst and mid-scan.
    cycle("unf_again", 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) cycle("burst", 1'b1, 1'b0, 17'(50 + i));
    cycle("burst_rd", 1'b0, 1'b1, '0);
    w_en = 1'b1; data_in = 17'd77;
    @(negedge clk);
    rst = 1'b1; #1;
    chk_reset("rst_burst");
    w_en = 1'b0;
    step(); rst = 1'b0; model_reset();
    TM = 1'b1; SI = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("scan_ovf_set", overflow, 1);
    chk("scan_unf_set", underflow, 1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk_reset("rst_scan");
    TM = 1'b0; SI = 1'b0;
    step(); rst = 1'b0; model_reset();
    cycle("post_w0", 1'b1, 1'b0, 17'h1FFFF);
    cycle("post_w1", 1'b1, 1'b0, 17'h00000);
    cycle("post_w2", 1'b1, 1'b1, 17'h15555);
    cycle("post_r0", 1'b0, 1'b1, '0);
    cycle("post_r1", 1'b0, 1'b1, '0);
    cycle("post_r2", 1'b0, 1'b1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
